// File: rtl/spi_stream_bridge.sv
// spi_stream_bridge: byte-stream to SPI-master register-port bridge with TX/RX FIFOs.
// Revision: 1.0
`default_nettype none

module spi_stream_bridge #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        spi_select_o,
    output logic [2:0]  mem_addr_o,
    output logic        read_n_o,
    output logic        write_n_o,
    output logic [15:0] data_from_cpu_o,
    input  logic [15:0] data_to_cpu_i,
    input  logic        dataavailable_i,
    input  logic        readyfordata_i,
    output logic        busy_o,
    output logic        rx_drop_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR1  = 3'd1,
        WR2  = 3'd2,
        RD1  = 3'd3,
        RD2  = 3'd4,
        GAP  = 3'd5
    } state_t;

    state_t          state_q;
    logic            started_q;
    logic            rx_drop_q;
    logic [7:0]      tx_mem_q [FIFO_DEPTH];
    logic [7:0]      rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_tx_empty, w_rx_full, w_wr, w_rd;
    logic w_unused_rd_hi;

    assign w_unused_rd_hi = ^data_to_cpu_i[15:8];

    assign tx_ready_o = (tx_cnt_q != C_FULL);
    assign w_tx_empty = (tx_cnt_q == '0);
    assign rx_valid_o = (rx_cnt_q != '0);
    assign w_rx_full  = (rx_cnt_q == C_FULL);

    assign w_tx_push = tx_valid_i && tx_ready_o;
    assign w_tx_pop  = (state_q == WR2);
    assign w_rx_push = (state_q == RD2);
    assign w_rx_pop  = rx_valid_o && rx_ready_i;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (w_tx_push && !w_tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
        if (!w_tx_push && w_tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        if (w_rx_push && !w_rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
        if (!w_rx_push && w_rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    end

    // Storage has no reset; visibility is gated by the counts instead.
    always_ff @(posedge clk_i) begin
        if (w_tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_data_i;
        if (w_rx_push) rx_mem_q[rx_wr_ptr_q] <= data_to_cpu_i[7:0];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            started_q   <= 1'b0;
            rx_drop_q   <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
        end else begin
            started_q <= 1'b1;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            if (w_tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
            if (w_tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
            if (w_rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
            if (w_rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
            if (state_q == IDLE && dataavailable_i && w_rx_full) rx_drop_q <= 1'b1;

            // started_q holds off the first access until the second edge after reset release.
            case (state_q)
                IDLE: begin
                    if (started_q) begin
                        if (dataavailable_i && !w_rx_full)      state_q <= RD1;
                        else if (readyfordata_i && !w_tx_empty) state_q <= WR1;
                    end
                end
                WR1:     state_q <= WR2;
                WR2:     state_q <= GAP;
                RD1:     state_q <= RD2;
                RD2:     state_q <= GAP;
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_wr = (state_q == WR1) || (state_q == WR2);
    assign w_rd = (state_q == RD1) || (state_q == RD2);

    assign spi_select_o    = w_wr || w_rd;
    assign write_n_o       = !w_wr;
    assign read_n_o        = !w_rd;
    assign mem_addr_o      = w_wr ? 3'd1 : 3'd0;
    assign data_from_cpu_o = w_wr ? {8'h00, tx_mem_q[tx_rd_ptr_q]} : 16'h0000;
    assign rx_data_o       = rx_valid_o ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
    assign busy_o          = (state_q != IDLE);
    assign rx_drop_o       = rx_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_stream_bridge.sv
// tb_spi_stream_bridge: randomized and directed checks against a queue-based transaction model.
// Revision: 1.0
`default_nettype none

module tb_spi_stream_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tx_data;
    logic        tx_valid, rx_ready, da, rfd;
    logic [15:0] dtc;
    logic        tx_ready_o, rx_valid_o, spi_select_o, read_n_o, write_n_o, busy_o, rx_drop_o;
    logic [7:0]  rx_data_o;
    logic [2:0]  mem_addr_o;
    logic [15:0] data_from_cpu_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_stream_bridge #(.FIFO_DEPTH(8)) dut (
        .clk_i(clk), .reset_i(reset),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .spi_select_o(spi_select_o), .mem_addr_o(mem_addr_o),
        .read_n_o(read_n_o), .write_n_o(write_n_o),
        .data_from_cpu_o(data_from_cpu_o), .data_to_cpu_i(dtc),
        .dataavailable_i(da), .readyfordata_i(rfd),
        .busy_o(busy_o), .rx_drop_o(rx_drop_o)
    );

    // Transaction model: queues for the FIFOs, plus the kind and cycle index of the access in flight.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int  kind;
    int  cnt;
    bit  armed, drop_m;
    logic        e_sel, e_rn, e_wn, e_busy, e_txr, e_rxv, e_drop;
    logic [2:0]  e_addr;
    logic [15:0] e_dfc;
    logic [7:0]  e_rxd;

    function automatic logic [33:0] obs();
        return {spi_select_o, read_n_o, write_n_o, mem_addr_o, data_from_cpu_o,
                busy_o, tx_ready_o, rx_valid_o, rx_data_o, rx_drop_o};
    endfunction

    function automatic logic [33:0] expv();
        return {e_sel, e_rn, e_wn, e_addr, e_dfc, e_busy, e_txr, e_rxv, e_rxd, e_drop};
    endfunction

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        kind = 0; cnt = 0; armed = 0; drop_m = 0;
    endtask

    task automatic predict();
        bit wr_act, rd_act;
        wr_act = (kind == 1) && (cnt <= 2);
        rd_act = (kind == 2) && (cnt <= 2);
        e_sel  = wr_act || rd_act;
        e_wn   = !wr_act;
        e_rn   = !rd_act;
        e_addr = wr_act ? 3'd1 : 3'd0;
        e_dfc  = 16'h0000;
        if (wr_act) e_dfc = {8'h00, txq[0]};
        e_busy = (kind != 0);
        e_txr  = (txq.size() < 8);
        e_rxv  = (rxq.size() > 0);
        e_rxd  = 8'h00;
        if (e_rxv) e_rxd = rxq[0];
        e_drop = drop_m;
    endtask

    task automatic advance();
        int ts, rs;
        bit txpush, rxpop;
        logic [7:0] din, dr;
        ts = txq.size();
        rs = rxq.size();
        txpush = tx_valid && (ts < 8);
        rxpop  = rx_ready && (rs > 0);
        din = tx_data;
        dr  = dtc[7:0];
        if (kind == 0 && da && rs == 8) drop_m = 1;
        if (kind == 1 && cnt == 2) void'(txq.pop_front());
        if (rxpop) void'(rxq.pop_front());
        if (kind == 2 && cnt == 2) rxq.push_back(dr);
        if (txpush) txq.push_back(din);
        if (kind != 0) begin
            if (cnt == 3) kind = 0;
            else cnt++;
        end else if (armed) begin
            if (da && rs < 8) begin kind = 2; cnt = 1; end
            else if (rfd && ts > 0) begin kind = 1; cnt = 1; end
        end
        armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        da = 1'b0; rfd = 1'b0; dtc = 16'h0000;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] want;
        want = {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        reset = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        da = 1'b0; rfd = 1'b0; dtc = 16'h0000;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== want) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", obs(), want);
        end
        tx_valid = 1'b1; tx_data = 8'h5A; da = 1'b1; rfd = 1'b1; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== want) begin
            failures++;
            $display("FAIL reset_held_with_activity got=%h want=%h", obs(), want);
        end
        do_reset();
    endtask

    task automatic test_write();
        int wn_low;
        logic [15:0] seen;
        wn_low = 0;
        seen = 16'h0;
        do_reset();
        rfd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tx_valid = (i == 0);
            tx_data  = 8'hA5;
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL write_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (!write_n_o) begin
                wn_low++;
                seen = data_from_cpu_o;
            end
            advance();
        end
        checks++;
        if (wn_low !== 2) begin
            failures++;
            $display("FAIL write_strobe_len got=%0d want=2", wn_low);
        end
        checks++;
        if (seen !== 16'h00A5) begin
            failures++;
            $display("FAIL write_data got=%h want=00a5", seen);
        end
    endtask

    task automatic test_read();
        int rn_low;
        rn_low = 0;
        do_reset();
        dtc = 16'h003C;
        for (int i = 0; i < 10; i++) begin
            da = (i < 4);
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL read_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (!read_n_o) rn_low++;
            advance();
        end
        checks++;
        if (rn_low !== 2) begin
            failures++;
            $display("FAIL read_strobe_len got=%0d want=2", rn_low);
        end
        checks++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL read_data got=%b/%h want=1/3c", rx_valid_o, rx_data_o);
        end
    endtask

    task automatic test_priority();
        int first;
        bit saw_read, saw_write;
        logic [15:0] wdata;
        first = 0; saw_read = 0; saw_write = 0; wdata = 16'h0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tx_valid = (i == 0);
            tx_data  = 8'h11;
            rfd = (i >= 1);
            da  = (i >= 1) && !saw_read;
            dtc = 16'($urandom);
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL prio_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (!read_n_o) begin
                saw_read = 1;
                if (first == 0) first = 1;
            end
            if (!write_n_o) begin
                saw_write = 1;
                wdata = data_from_cpu_o;
                if (first == 0) first = 2;
            end
            advance();
        end
        checks++;
        if (first !== 1 || !saw_write || wdata !== 16'h0011) begin
            failures++;
            $display("FAIL prio_order first=%0d write_seen=%0d wdata=%h want first=1 write_seen=1 wdata=0011",
                     first, saw_write, wdata);
        end
    endtask

    task automatic test_rx_full();
        int late_reads, resumed;
        late_reads = 0; resumed = 0;
        do_reset();
        da = 1'b1;
        for (int i = 0; i < 60; i++) begin
            dtc = 16'($urandom);
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rxfull_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (i >= 45 && !read_n_o) late_reads++;
            advance();
        end
        checks++;
        if (late_reads !== 0 || rx_drop_o !== 1'b1) begin
            failures++;
            $display("FAIL rxfull_stall late_reads=%0d drop=%b want 0 and 1", late_reads, rx_drop_o);
        end
        for (int i = 0; i < 12; i++) begin
            rx_ready = (i == 0);
            dtc = 16'($urandom);
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rxresume_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (!read_n_o) resumed++;
            advance();
        end
        checks++;
        if (resumed !== 2) begin
            failures++;
            $display("FAIL rx_resume read_cycles=%0d want=2", resumed);
        end
        da = 1'b0;
    endtask

    task automatic test_tx_full();
        logic [7:0] got[$];
        bit prev_wn;
        prev_wn = 1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(i + 1);
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL txfill_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (i == 8) begin
                checks++;
                if (tx_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_full_ready got=%b want=0", tx_ready_o);
                end
            end
            advance();
        end
        tx_valid = 1'b0;
        rfd = 1'b1;
        for (int i = 0; i < 45; i++) begin
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL txdrain_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (!write_n_o && prev_wn) got.push_back(data_from_cpu_o[7:0]);
            prev_wn = write_n_o;
            advance();
        end
        checks++;
        if (got.size() !== 8) begin
            failures++;
            $display("FAIL tx_order_count got=%0d want=8", got.size());
        end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            checks++;
            if (got[k] !== 8'(k + 1)) begin
                failures++;
                $display("FAIL tx_order_byte%0d got=%h want=%h", k, got[k], 8'(k + 1));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        found = 0;
        do_reset();
        rfd = 1'b1;
        for (int i = 0; i < 12 && !found; i++) begin
            tx_valid = (i == 0);
            tx_data  = 8'h77;
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL midwr_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            if (kind == 1 && cnt == 2) found = 1;
            else advance();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midwr_timeout reached_wr2=0 want=1");
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({write_n_o, spi_select_o, tx_ready_o, rx_valid_o} !== 4'b1010) begin
            failures++;
            $display("FAIL midwr_async_reset got wn/sel/txr/rxv=%b want=1010",
                     {write_n_o, spi_select_o, tx_ready_o, rx_valid_o});
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tx_valid = $urandom_range(0, 1) == 1;
            tx_data  = 8'($urandom);
            rx_ready = ((i % 400) < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            da  = $urandom_range(0, 2) == 0;
            rfd = $urandom_range(0, 1) == 1;
            dtc = 16'($urandom);
            predict();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h want=%h", i, obs(), expv());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_rx_full();
        test_tx_full();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
